// File: rtl/voting_machine_multi.sv
// Parametrised voting machine: NUM_CAND buttons, hold-time qualification,
// multi-press rejection, per-candidate saturating tallies, and an LED readout
// of a selected tally in display mode.
module voting_machine_multi #(
    parameter int NUM_CAND    = 4,
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 5,
    parameter int SEL_W       = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic [NUM_CAND-1:0] button,
    input  logic [SEL_W-1:0]    sel,
    output logic [CNT_W-1:0]    led,
    output logic                vote_valid,
    output logic                vote_err,
    output logic [NUM_CAND-1:0] sat
);

    // state          | meaning
    // S_IDLE         | waiting for a press (mode 0) or parked (mode 1)
    // S_HOLD         | single button held, qualifying hold time
    // S_WAIT_RELEASE | vote committed or press rejected; wait for all buttons low
    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_HOLD         = 2'd1,
        S_WAIT_RELEASE = 2'd2
    } state_t;

    localparam int HW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam int IW = $clog2(NUM_CAND);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              state_q, state_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [IW-1:0]       cand_q, cand_d;
    logic [CNT_W-1:0]    cnt_q [NUM_CAND];
    logic [NUM_CAND-1:0] sat_q;
    logic [CNT_W-1:0]    led_q, led_d;
    logic                vote_valid_q, vote_err_q;

    logic                one_hot;
    logic [IW-1:0]       btn_idx;
    logic [NUM_CAND-1:0] cand_mask;
    logic                commit;
    logic [IW-1:0]       commit_idx;
    logic                err;

    // Classify the button vector: exactly-one-high and index of that bit.
    always_comb begin
        one_hot = (button != '0) && ((button & (button - 1'b1)) == '0);
        btn_idx = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (button[i]) btn_idx = IW'(i);
        end
        cand_mask = {{(NUM_CAND-1){1'b0}}, 1'b1} << cand_q;
    end

    // Next-state, hold counter and commit/error decisions.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        cand_d     = cand_q;
        commit     = 1'b0;
        commit_idx = cand_q;
        err        = 1'b0;
        if (mode) begin
            state_d = S_IDLE;
            hold_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (one_hot) begin
                        cand_d = btn_idx;
                        if (HOLD_CYCLES == 1) begin
                            commit     = 1'b1;
                            commit_idx = btn_idx;
                            state_d    = S_WAIT_RELEASE;
                        end else begin
                            hold_d  = HW'(1);
                            state_d = S_HOLD;
                        end
                    end else if (button != '0) begin
                        err     = 1'b1;
                        state_d = S_WAIT_RELEASE;
                    end
                end
                S_HOLD: begin
                    if (button == cand_mask) begin
                        if (hold_q + HW'(1) == HW'(HOLD_CYCLES)) begin
                            commit  = 1'b1;
                            hold_d  = '0;
                            state_d = S_WAIT_RELEASE;
                        end else begin
                            hold_d = hold_q + HW'(1);
                        end
                    end else if (button == '0) begin
                        hold_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        err     = 1'b1;
                        hold_d  = '0;
                        state_d = S_WAIT_RELEASE;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (button == '0) state_d = S_IDLE;
                end
                default: begin
                    hold_d  = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // FSM registers, saturating tallies, sticky saturation flags and pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            cand_q       <= '0;
            vote_valid_q <= 1'b0;
            vote_err_q   <= 1'b0;
            sat_q        <= '0;
            for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            cand_q       <= cand_d;
            vote_valid_q <= commit;
            vote_err_q   <= err;
            for (int i = 0; i < NUM_CAND; i++) begin
                if (commit && commit_idx == IW'(i)) begin
                    // The flag marks the commit that lands on (or hits) the ceiling.
                    if (cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + 1'b1;
                    if (cnt_q[i] >= CNT_MAX - 1'b1) sat_q[i] <= 1'b1;
                end
            end
        end
    end

    // Display mux: selected tally in mode 1, blank otherwise or for out-of-range sel.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (mode && sel == SEL_W'(i)) led_d = cnt_q[i];
        end
    end

    // Registered LED bus.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) led_q <= '0;
        else        led_q <= led_d;
    end

    assign led        = led_q;
    assign vote_valid = vote_valid_q;
    assign vote_err   = vote_err_q;
    assign sat        = sat_q;

endmodule

// File: doc/voting_machine_multi.md
Name: voting_machine_multi

Overview:
- Parametrised successor to the four-button voting machine: NUM_CAND candidates, per-candidate saturating tally counters, press qualification by hold time, and one-hot/multi-press rejection.
- Mode 0 collects votes; mode 1 displays the tally of a selected candidate on the LED bus.
- Sits between the debounced front-panel buttons and the LED display driver.

Parameters:
- NUM_CAND, 4, number of candidates (buttons and tally counters), range 2..16.
- CNT_W, 8, width of each tally counter and of led.
- HOLD_CYCLES, 5, consecutive sampled-high clocks that qualify a press, minimum 1.
- SEL_W, 4, width of sel; must satisfy 2**SEL_W >= NUM_CAND.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- mode  in  1  0 = voting, 1 = result display.
- button  in  NUM_CAND  candidate buttons, active-high, already synchronous to clock.
- sel  in  SEL_W  candidate index shown in mode 1.
- led  out  CNT_W  display output.
- vote_valid  out  1  one-cycle pulse when a vote is committed.
- vote_err  out  1  one-cycle pulse when a multi-button press is rejected.
- sat  out  NUM_CAND  sticky per-candidate flag: counter reached its maximum.

Behaviour:
- Reset (reset=0, asynchronous): all counters 0, FSM=IDLE, hold counter 0, led=0, vote_valid=0, vote_err=0, sat=0. Reset asserted mid-press discards the press; no partial commit.
- FSM states: IDLE, HOLD, WAIT_RELEASE.
- IDLE, mode=0:
  - exactly one button bit high -> latch its index, hold count = 1, go to HOLD (HOLD_CYCLES=1 commits directly on this edge and goes to WAIT_RELEASE).
  - more than one bit high -> vote_err pulse, go to WAIT_RELEASE.
  - none high -> stay in IDLE.
- HOLD:
  - same single button still high -> hold count increments. On the edge where it reaches HOLD_CYCLES: commit and go to WAIT_RELEASE.
  - button dropped -> IDLE, no vote.
  - a different or extra button appears -> vote_err, WAIT_RELEASE.
  - mode=1 -> IDLE, no vote, no error.
- Commit: the latched candidate's counter increments by 1 and vote_valid is registered high for exactly one cycle.
  - With a button first sampled high at edge E0, the count is updated at edge E(HOLD_CYCLES-1).
- WAIT_RELEASE: stays until button == 0 is sampled, then IDLE. A held button never yields a second vote.
- Saturation: a counter at 2**CNT_W-1 does not wrap. A commit to it still pulses vote_valid and sets its sat bit. sat bits clear only on reset.
- mode=1: buttons ignored; FSM is forced to IDLE on the next edge.
- led is registered and updates one cycle after a mode, sel, or count change:
  - mode=0 -> 0.
  - mode=1 -> count[sel].
  - mode=1 with sel >= NUM_CAND -> 0.
- vote_valid and vote_err are never high in the same cycle.
- Mode transitions do not alter counters.

Test Plan:
- Reset then single votes: button[0]=1 for 5 clocks, release. Repeat for button[1], [2], [3]. Then mode=1 and sweep sel 0..3 -> four vote_valid pulses; led=0x01 for each sel. sel=5 -> led=0x00.
- Short press: button[2]=1 for 4 clocks -> no vote_valid; count[2] unchanged.
- Long hold: button[1]=1 for 40 clocks -> exactly one vote_valid; count[1]=1.
- Multi-press: button=4'b0011 -> vote_err one cycle, no count change. Holding it for 20 clocks gives no further pulses until release.
- Saturation: CNT_W=3, 9 qualified presses of button[3] -> count[3]=7, sat[3]=1, 9 vote_valid pulses.
- Async reset mid-hold: reset=0 between clock edges during the 3rd hold cycle -> led, counts, and sat are 0 immediately. After release of reset, a fresh 5-clock press counts 1. Also: mode=1 raised at hold cycle 3 -> no vote.
